// File: rtl/hex_mult_pkg.sv
// Shared widths and control-FSM state encodings for the hex multiplier.
// The FSM and the datapath both import these definitions.
package hex_mult_pkg;

    localparam int OP_W     = 16;
    localparam int DIGIT_W  = 4;
    localparam int N_DIGITS = OP_W / DIGIT_W;
    localparam int PROD_W   = 2 * OP_W;

    typedef enum logic [2:0] {
        IDLE,
        COMPUTE_1,
        COMPUTE_2,
        COMPUTE_3,
        COMPUTE_4,
        COMPUTE_5,
        COMPUTE_6
    } mult_state_e;

endpackage

// File: rtl/hex_mult_datapath_digit_pp_gen.sv
// Combinational partial product for one hex digit of the multiplier,
// shifted to that digit's position within the full product.
module digit_pp_gen #(
    parameter int OP_W    = hex_mult_pkg::OP_W,
    parameter int DIGIT_W = hex_mult_pkg::DIGIT_W,
    parameter int CNT_W   = 3
) (
    input  logic [OP_W-1:0]    a_q,
    input  logic [DIGIT_W-1:0] digit,
    input  logic [CNT_W-1:0]   cnt,
    output logic [2*OP_W-1:0]  pp
);

    localparam int RAW_W  = OP_W + DIGIT_W;
    localparam int PROD_W = 2 * OP_W;

    logic [RAW_W-1:0] raw;

    always_comb begin
        raw = RAW_W'(a_q) * RAW_W'(digit);
        pp  = PROD_W'(raw) << (int'(cnt) * DIGIT_W);
    end

endmodule

// File: rtl/hex_mult_datapath.sv
// Hex multiplier datapath: operand latch, digit counter, one-stage
// partial-product pipeline into the accumulator, and result capture.
module hex_mult_datapath #(
    parameter int OP_W    = hex_mult_pkg::OP_W,
    parameter int DIGIT_W = hex_mult_pkg::DIGIT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                start,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    input  logic                mux_en,
    input  logic                adder_en,
    input  logic                done,
    output logic                busy,
    output logic [2*OP_W-1:0]   product,
    output logic                product_valid
);

    localparam int N_DIGITS = OP_W / DIGIT_W;
    localparam int PROD_W   = 2 * OP_W;
    localparam int CNT_W    = $clog2(N_DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIGITS);

    logic [OP_W-1:0]    a_q;
    logic [OP_W-1:0]    b_q;
    logic [CNT_W-1:0]   cnt;
    logic [PROD_W-1:0]  pp;
    logic [PROD_W-1:0]  acc;

    logic [OP_W-1:0]    b_sh;
    logic [DIGIT_W-1:0] digit;
    logic [PROD_W-1:0]  pp_next;
    logic [PROD_W-1:0]  acc_sum;
    logic               step;

    always_comb begin
        b_sh    = b_q >> (int'(cnt) * DIGIT_W);
        digit   = b_sh[DIGIT_W-1:0];
        step    = busy && mux_en && (cnt < LAST);
        // Capture must see the accumulate happening in the same cycle.
        acc_sum = acc + (adder_en ? pp : '0);
    end

    digit_pp_gen #(
        .OP_W    (OP_W),
        .DIGIT_W (DIGIT_W),
        .CNT_W   (CNT_W)
    ) u_pp_gen (
        .a_q   (a_q),
        .digit (digit),
        .cnt   (cnt),
        .pp    (pp_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q           <= '0;
            b_q           <= '0;
            cnt           <= '0;
            pp            <= '0;
            acc           <= '0;
            busy          <= 1'b0;
            product       <= '0;
            product_valid <= 1'b0;
        end else begin
            product_valid <= 1'b0;
            if (start && enable && !busy) begin
                a_q  <= a;
                b_q  <= b;
                cnt  <= '0;
                pp   <= '0;
                acc  <= '0;
                busy <= 1'b1;
            end else if (busy && !enable) begin
                cnt  <= '0;
                pp   <= '0;
                acc  <= '0;
                busy <= 1'b0;
            end else if (busy) begin
                pp <= step ? pp_next : '0;
                if (step)
                    cnt <= cnt + CNT_W'(1);
                if (adder_en)
                    acc <= acc_sum;
                if (done) begin
                    product       <= acc_sum;
                    product_valid <= 1'b1;
                    busy          <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_mult_datapath.sv
// Directed bench for hex_mult_datapath driving the nominal FSM strobes.
module tb_hex_mult_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        mux_en;
    logic        adder_en;
    logic        done;
    logic        busy;
    logic [31:0] product;
    logic        product_valid;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hex_mult_datapath dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .start         (start),
        .a             (a),
        .b             (b),
        .mux_en        (mux_en),
        .adder_en      (adder_en),
        .done          (done),
        .busy          (busy),
        .product       (product),
        .product_valid (product_valid)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after capture.
    task automatic run_op(input string tag, input logic [15:0] av,
                          input logic [15:0] bv, input logic [31:0] exp);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start    = 1'b0;
        mux_en   = 1'b1;
        adder_en = 1'b1;
        check({tag, " busy c1"}, 32'(busy), 32'd1);
        check({tag, " valid c1"}, 32'(product_valid), 32'd0);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
        end
        @(negedge clk);
        mux_en = 1'b0;
        done   = 1'b1;
        check({tag, " busy c6"}, 32'(busy), 32'd1);
        check({tag, " valid c6"}, 32'(product_valid), 32'd0);
        @(negedge clk);
        done     = 1'b0;
        adder_en = 1'b0;
        check({tag, " valid"}, 32'(product_valid), 32'd1);
        check({tag, " product"}, product, exp);
        check({tag, " busy end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        mux_en   = 1'b0;
        adder_en = 1'b0;
        done     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst product", product, 32'd0);
        check("rst valid", 32'(product_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("p1234", 16'h1234, 16'h5678, 32'h0626_0060);
        @(negedge clk);
        check("p1234 valid drop", 32'(product_valid), 32'd0);
        check("p1234 hold", product, 32'h0626_0060);

        run_op("pffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run_op("pzero", 16'h0000, 16'hABCD, 32'h0000_0000);
        run_op("pmsb", 16'h0001, 16'h8000, 32'h0000_8000);
        @(negedge clk);

        // Second start mid-operation must not resample operands.
        start = 1'b1; a = 16'h1234; b = 16'h5678;
        @(negedge clk);
        start = 1'b0; mux_en = 1'b1; adder_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 16'h9999; b = 16'h9999;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mux_en = 1'b0; done = 1'b1;
        @(negedge clk);
        done = 1'b0; adder_en = 1'b0;
        check("ign valid", 32'(product_valid), 32'd1);
        check("ign product", product, 32'h0626_0060);
        @(negedge clk);

        // Abort via enable in cycle 3.
        start = 1'b1; a = 16'h0003; b = 16'h0003;
        @(negedge clk);
        start = 1'b0; mux_en = 1'b1; adder_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1; mux_en = 1'b0; adder_en = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort valid", 32'(product_valid), 32'd0);
        check("abort hold", product, 32'h0626_0060);
        @(negedge clk);
        check("abort valid2", 32'(product_valid), 32'd0);
        run_op("post_abort", 16'h0021, 16'h0102, 32'h0000_2142);
        @(negedge clk);

        // Reset in cycle 4 discards the operation.
        start = 1'b1; a = 16'h00FF; b = 16'h00FF;
        @(negedge clk);
        start = 1'b0; mux_en = 1'b1; adder_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; mux_en = 1'b0; adder_en = 1'b0;
        check("mrst busy", 32'(busy), 32'd0);
        check("mrst product", product, 32'd0);
        check("mrst valid", 32'(product_valid), 32'd0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("idle done valid", 32'(product_valid), 32'd0);
        check("idle done busy", 32'(busy), 32'd0);
        check("idle done product", product, 32'd0);

        run_op("bb1", 16'h0003, 16'h0005, 32'h0000_000F);
        run_op("bb2", 16'h0100, 16'h0100, 32'h0001_0000);
        @(negedge clk);
        check("bb2 valid drop", 32'(product_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
